veritune_mic_decimator: RTL and testbench

Upstream front end for the veritune record path. It synchronises the raw 1-bit Mic pin, samples it at a programmable rate and counts ones over a fixed window (boxcar decimation), producing a saturated multi-bit audio sample with a one-cycle valid strobe. The record state machine consumes the sample stream while q_Rec is high. The block also tracks the peak sample and a sticky clip flag for the LED/SSD level display.

---
 rtl/veritune_mic_decimator.sv | 102 ++++++++++
 tb/tb_veritune_mic_decimator.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/veritune_mic_decimator.sv
// Boxcar decimator for the 1-bit microphone stream on the veritune record path.
// It produces saturated multi-bit samples with a one-cycle valid strobe, and tracks the peak and a sticky clip flag.
module veritune_mic_decimator #(
  parameter int SAMPLE_DIV = 50,
  parameter int DECIM      = 256,
  parameter int OUT_W      = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Mic,
  input  logic             Enable,
  input  logic             Clear_Peak,
  output logic [OUT_W-1:0] Sample,
  output logic             Sample_Valid,
  output logic [OUT_W-1:0] Peak,
  output logic             Clip
);

  localparam int PC_W  = $clog2(SAMPLE_DIV);
  localparam int WIN_W = $clog2(DECIM);
  localparam int ACC_W = $clog2(DECIM + 1);
  localparam int SUM_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SAMPLE_DIV - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DECIM - 1);
  localparam logic [SUM_W-1:0] SAT      = SUM_W'({OUT_W{1'b1}});
  localparam logic [SUM_W-1:0] FULL     = SUM_W'(DECIM);

  logic             mic_meta;
  logic             mic_s;
  logic [PC_W-1:0]  pc;
  logic [WIN_W-1:0] win;
  logic [ACC_W-1:0] acc;

  logic             tick;
  logic             win_end;
  logic [SUM_W-1:0] sum;
  logic [OUT_W-1:0] new_sample;
  logic             new_clip;

  // sum already includes the current tick, so the last bit of the window lands in Sample
  always_comb begin
    tick       = Enable && (pc == PC_LAST);
    win_end    = tick && (win == WIN_LAST);
    sum        = SUM_W'(acc) + SUM_W'(mic_s);
    new_sample = (sum > SAT) ? OUT_W'(SAT) : OUT_W'(sum);
    new_clip   = (sum == FULL);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      mic_meta     <= 1'b0;
      mic_s        <= 1'b0;
      pc           <= '0;
      win          <= '0;
      acc          <= '0;
      Sample       <= '0;
      Sample_Valid <= 1'b0;
      Peak         <= '0;
      Clip         <= 1'b0;
    end else begin
      mic_meta     <= Mic;
      mic_s        <= mic_meta;
      Sample_Valid <= 1'b0;

      // dropping Enable discards any partial window so re-enabling starts aligned
      if (!Enable) begin
        pc  <= '0;
        win <= '0;
        acc <= '0;
      end else if (tick) begin
        pc <= '0;
        if (win_end) begin
          win          <= '0;
          acc          <= '0;
          Sample       <= new_sample;
          Sample_Valid <= 1'b1;
        end else begin
          win <= win + WIN_W'(1);
          acc <= acc + ACC_W'(mic_s);
        end
      end else begin
        pc <= pc + PC_W'(1);
      end

      // a completing window takes priority over a coincident Clear_Peak
      if (win_end) begin
        if (Clear_Peak) begin
          Peak <= new_sample;
          Clip <= new_clip;
        end else begin
          if (new_sample > Peak) Peak <= new_sample;
          Clip <= Clip | new_clip;
        end
      end else if (Clear_Peak) begin
        Peak <= '0;
        Clip <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_veritune_mic_decimator.sv
// Directed bench for veritune_mic_decimator with SAMPLE_DIV=4, DECIM=8 (one strobe per 32 enabled cycles).
module tb_veritune_mic_decimator;

  localparam int SAMPLE_DIV = 4;
  localparam int DECIM      = 8;
  localparam int OUT_W      = 8;
  localparam int WINDOW     = SAMPLE_DIV * DECIM;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Mic;
  logic             Enable;
  logic             Clear_Peak;
  logic [OUT_W-1:0] Sample;
  logic             Sample_Valid;
  logic [OUT_W-1:0] Peak;
  logic             Clip;

  logic       mic_lvl  = 1'b0;
  logic       sq_mode  = 1'b0;
  logic [2:0] sq_cnt   = 3'd0;
  int         checks   = 0;
  int         errors   = 0;
  int         gap;
  logic       seen;

  always #5 Clk = ~Clk;

  // square wave of 4 cycles high / 4 low for the half-scale test
  always @(negedge Clk) sq_cnt <= sq_cnt + 3'd1;
  assign Mic = sq_mode ? sq_cnt[2] : mic_lvl;

  veritune_mic_decimator #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .DECIM     (DECIM),
    .OUT_W     (OUT_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Mic         (Mic),
    .Enable      (Enable),
    .Clear_Peak  (Clear_Peak),
    .Sample      (Sample),
    .Sample_Valid(Sample_Valid),
    .Peak        (Peak),
    .Clip        (Clip)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // counts edges until a strobe is seen, -1 if none within a bound
  task automatic waitStrobe(output int edges);
    edges = -1;
    for (int i = 1; i <= 3 * WINDOW; i++) begin
      @(negedge Clk);
      if (Sample_Valid) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic applyReset(input int n);
    Reset = 1'b0;
    stepCycles(n);
    Reset = 1'b1;
  endtask

  initial begin
    Reset      = 1'b0;
    Enable     = 1'b1;
    Clear_Peak = 1'b0;
    mic_lvl    = 1'b1;

    // reset with Mic and Enable active
    stepCycles(3);
    checkOutput("rst_sample", Sample, 0);
    checkOutput("rst_valid", Sample_Valid, 0);
    checkOutput("rst_peak", Peak, 0);
    checkOutput("rst_clip", Clip, 0);
    Reset = 1'b1;

    // constant ones: full-scale windows
    waitStrobe(gap);
    checkOutput("full_first_gap", gap, WINDOW);
    checkOutput("full_sample", Sample, 8);
    checkOutput("full_clip", Clip, 1);
    checkOutput("full_peak", Peak, 8);
    stepCycles(1);
    checkOutput("full_valid_one_cycle", Sample_Valid, 0);
    waitStrobe(gap);
    checkOutput("full_second_gap", gap, WINDOW - 1);
    checkOutput("full_sample2", Sample, 8);

    // square wave: half-scale windows, no clip
    applyReset(2);
    sq_mode = 1'b1;
    waitStrobe(gap);
    checkOutput("sq_gap", gap, WINDOW);
    checkOutput("sq_sample", Sample, 4);
    checkOutput("sq_clip", Clip, 0);
    checkOutput("sq_peak", Peak, 4);
    waitStrobe(gap);
    checkOutput("sq_sample2", Sample, 4);
    checkOutput("sq_peak2", Peak, 4);

    // enable drop discards the partial window
    sq_mode = 1'b0;
    mic_lvl = 1'b1;
    applyReset(2);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) Enable = 1'b0;
      @(negedge Clk);
      seen |= Sample_Valid;
    end
    checkOutput("drop_no_strobe", seen, 0);
    Enable = 1'b1;
    waitStrobe(gap);
    checkOutput("reenable_gap", gap, WINDOW);
    checkOutput("reenable_sample", Sample, 8);
    checkOutput("reenable_clip", Clip, 1);

    // Clear_Peak coincident with a Sample=4 strobe: new window wins
    Enable  = 1'b0;
    sq_mode = 1'b1;
    stepCycles(4);
    Enable = 1'b1;
    stepCycles(WINDOW - 1);
    checkOutput("coin_pre_valid", Sample_Valid, 0);
    Clear_Peak = 1'b1;
    stepCycles(1);
    Clear_Peak = 1'b0;
    checkOutput("coin_valid", Sample_Valid, 1);
    checkOutput("coin_sample", Sample, 4);
    checkOutput("coin_peak", Peak, 4);
    checkOutput("coin_clip", Clip, 0);

    // rebuild Peak=8/Clip=1, then clear while idle with Mic low
    Enable  = 1'b0;
    sq_mode = 1'b0;
    mic_lvl = 1'b1;
    stepCycles(4);
    Enable = 1'b1;
    waitStrobe(gap);
    checkOutput("rebuild_peak", Peak, 8);
    checkOutput("rebuild_clip", Clip, 1);
    Enable  = 1'b0;
    mic_lvl = 1'b0;
    stepCycles(2);
    Clear_Peak = 1'b1;
    stepCycles(1);
    Clear_Peak = 1'b0;
    checkOutput("clr_peak", Peak, 0);
    checkOutput("clr_clip", Clip, 0);
    checkOutput("clr_sample_hold", Sample, 8);
    stepCycles(2);
    Enable = 1'b1;
    waitStrobe(gap);
    checkOutput("zero_gap", gap, WINDOW);
    checkOutput("zero_sample", Sample, 0);
    checkOutput("zero_peak", Peak, 0);

    // reset mid-window with win=5
    mic_lvl = 1'b1;
    Enable  = 1'b0;
    stepCycles(4);
    Enable = 1'b1;
    stepCycles(22);
    checkOutput("mid_win_pre", dut.win, 5);
    Reset = 1'b0;
    stepCycles(1);
    checkOutput("mid_win", dut.win, 0);
    checkOutput("mid_acc", dut.acc, 0);
    checkOutput("mid_pc", dut.pc, 0);
    checkOutput("mid_sample", Sample, 0);
    checkOutput("mid_peak", Peak, 0);
    checkOutput("mid_clip", Clip, 0);
    Reset = 1'b1;
    waitStrobe(gap);
    checkOutput("post_rst_gap", gap, WINDOW);
    checkOutput("post_rst_sample", Sample, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
